// File: rtl/ex_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// ex_multicycle_ctrl_if
// Handshake bundle between the ID/EX pipeline and the multi-cycle sequencing
// controller.
//   stallreq_id : load-use hazard from ID (same-cycle)
//   mc_req      : EX holds a multi-cycle op
//   mc_cycles   : total EX cycles for that op
//   flush_i     : pipeline flush request
//   stall       : per-stage stall vector (bit0 PC .. bit4 MEM/WB, bit5 reserved)
//   flush_o     : flush to pipeline registers
//   mc_busy     : sequence in progress
//   mc_last     : final cycle of the multi-cycle op (EX commits)
//   mc_count    : current counter value
// master = pipeline side, slave = controller side.
// ----------------------------------------------------------------------------
interface ex_multicycle_ctrl_if #(
   parameter int CNT_W   = 6,
   parameter int STALL_W = 6
);
   logic               stallreq_id;
   logic               mc_req;
   logic [CNT_W-1:0]   mc_cycles;
   logic               flush_i;
   logic [STALL_W-1:0] stall;
   logic               flush_o;
   logic               mc_busy;
   logic               mc_last;
   logic [CNT_W-1:0]   mc_count;

   modport master (
      output stallreq_id, mc_req, mc_cycles, flush_i,
      input  stall, flush_o, mc_busy, mc_last, mc_count
   );

   modport slave (
      input  stallreq_id, mc_req, mc_cycles, flush_i,
      output stall, flush_o, mc_busy, mc_last, mc_count
   );
endinterface

// File: rtl/ex_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// ex_multicycle_ctrl
// Sequences multi-cycle EX operations (madd/msub, div) with a down-counter,
// merges the ID load-use stall request and drives the per-stage stall vector.
// A flush cancels any in-flight sequence.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset; forces all outputs to 0
//   bus  : ex_multicycle_ctrl_if.slave (see interface header)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no multi-cycle op in flight; accepts mc_req with mc_cycles >= 2
// RUN   | counting down; cnt holds remaining EX cycles, mc_last at cnt==1
// ----------------------------------------------------------------------------
module ex_multicycle_ctrl #(
   parameter int CNT_W   = 6,
   parameter int STALL_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   ex_multicycle_ctrl_if.slave   bus
);

   localparam logic [STALL_W-1:0] STALL_NONE = '0;
   localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
   localparam logic [STALL_W-1:0] STALL_EX   = STALL_W'(6'b001111);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [STALL_W-1:0] stall_c;
   logic               last_c;
   logic [STALL_W-1:0] stall_id_c;

   assign stall_id_c = bus.stallreq_id ? STALL_ID : STALL_NONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_c   = STALL_NONE;
      last_c    = 1'b0;

      if (bus.flush_i) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               // Ops of 0 or 1 cycles complete in a single EX cycle and
               // never enter RUN.
               if (bus.mc_req && (bus.mc_cycles >= CNT_W'(2))) begin
                  stall_c   = STALL_EX;
                  cnt_nxt   = bus.mc_cycles - CNT_W'(1);
                  state_nxt = RUN;
               end else begin
                  stall_c   = stall_id_c;
               end
            end
            RUN: begin
               if (cnt > CNT_W'(1)) begin
                  stall_c = STALL_EX;
                  cnt_nxt = cnt - CNT_W'(1);
               end else begin
                  // Final cycle: EX commits, so EX/MEM may advance; only
                  // the load-use request can still hold the front end.
                  last_c    = 1'b1;
                  stall_c   = stall_id_c;
                  cnt_nxt   = '0;
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.stall    = rst ? STALL_NONE : stall_c;
   assign bus.flush_o  = bus.flush_i & ~rst;
   assign bus.mc_busy  = (state == RUN) & ~rst;
   assign bus.mc_last  = last_c & ~rst;
   assign bus.mc_count = rst ? '0 : cnt;

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
module tb_ex_multicycle_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ex_multicycle_ctrl_if #(.CNT_W(6), .STALL_W(6)) bus ();

   ex_multicycle_ctrl #(.CNT_W(6), .STALL_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- behavioural model ----------------
   // An accepted op is remembered by its acceptance cycle t0 and length n.
   // Everything else is derived from k = t - t0.
   int  t_now    = 0;
   bit  op_valid = 0;
   int  op_t0    = 0;
   int  op_n     = 0;

   logic [5:0] e_stall;
   bit         e_last, e_busy, e_fo;
   int         e_cnt, k;
   bit         running, accept, finish;

   always @(negedge clk) begin
      e_stall = 6'b000000;
      e_last  = 0;
      e_busy  = 0;
      e_cnt   = 0;
      e_fo    = 0;
      accept  = 0;
      finish  = 0;
      running = op_valid && (t_now > op_t0);
      k       = t_now - op_t0;
      if (!rst) begin
         e_fo = bus.flush_i;
         if (running) begin
            e_busy = 1;
            e_cnt  = op_n - k;
            if (k == op_n - 1) finish = 1;
            if (!bus.flush_i) begin
               if (k < op_n - 1)          e_stall = 6'b001111;
               else if (bus.stallreq_id)  e_stall = 6'b000111;
               e_last = (k == op_n - 1);
            end
         end else if (!bus.flush_i) begin
            if (bus.mc_req && int'(bus.mc_cycles) >= 2) begin
               e_stall = 6'b001111;
               accept  = 1;
            end else if (bus.stallreq_id) begin
               e_stall = 6'b000111;
            end
         end
      end
      n_cmp++;
      if (bus.stall !== e_stall || bus.mc_last !== e_last || bus.mc_busy !== e_busy ||
          bus.flush_o !== e_fo || int'(bus.mc_count) != e_cnt || $isunknown(bus.mc_count)) begin
         n_bad++;
         $display("FAIL model t=%0d: got stall=%b last=%b busy=%b flush_o=%b count=%0d, want stall=%b last=%b busy=%b flush_o=%b count=%0d",
                  t_now, bus.stall, bus.mc_last, bus.mc_busy, bus.flush_o, bus.mc_count,
                  e_stall, e_last, e_busy, e_fo, e_cnt);
      end
      // state as of the next posedge
      if (rst || bus.flush_i || finish) op_valid = 0;
      if (accept && !rst) begin
         op_valid = 1;
         op_t0    = t_now;
         op_n     = int'(bus.mc_cycles);
      end
      t_now++;
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input bit r, input bit req, input int n, input bit id, input bit fl);
      @(posedge clk);
      #1;
      rst             = r;
      bus.mc_req      = req;
      bus.mc_cycles   = 6'(n);
      bus.stallreq_id = id;
      bus.flush_i     = fl;
      @(negedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [5:0] st, input bit last,
                      input bit busy, input int cnt, input bit fo);
      n_cmp++;
      if (bus.stall !== st || bus.mc_last !== last || bus.mc_busy !== busy ||
          int'(bus.mc_count) != cnt || bus.flush_o !== fo) begin
         n_bad++;
         $display("FAIL %s: got stall=%b last=%b busy=%b count=%0d flush_o=%b, want stall=%b last=%b busy=%b count=%0d flush_o=%b",
                  name, bus.stall, bus.mc_last, bus.mc_busy, bus.mc_count, bus.flush_o,
                  st, last, busy, cnt, fo);
      end
   endtask

   initial begin
      rst             = 1'b1;
      bus.mc_req      = 1'b1;
      bus.mc_cycles   = 6'd5;
      bus.stallreq_id = 1'b0;
      bus.flush_i     = 1'b1;

      // reset with active requests
      cyc(1, 1, 5, 0, 1); lit("reset_c0", 6'b000000, 0, 0, 0, 0);
      cyc(1, 1, 5, 0, 1); lit("reset_c1", 6'b000000, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0); lit("post_reset_idle", 6'b000000, 0, 0, 0, 0);

      // basic 4-cycle sequence
      cyc(0, 1, 4, 0, 0); lit("basic_T0", 6'b001111, 0, 0, 0, 0);
      cyc(0, 1, 4, 0, 0); lit("basic_T1", 6'b001111, 0, 1, 3, 0);
      cyc(0, 1, 4, 0, 0); lit("basic_T2", 6'b001111, 0, 1, 2, 0);
      cyc(0, 1, 4, 0, 0); lit("basic_T3", 6'b000000, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0); lit("basic_T4", 6'b000000, 0, 0, 0, 0);

      // short ops and ID stall
      cyc(0, 1, 1, 0, 0); lit("short_1",  6'b000000, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0); lit("short_0",  6'b000000, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 0); lit("short_id", 6'b000111, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0); lit("id_stall", 6'b000111, 0, 0, 0, 0);

      // load-use overlapping a 3-cycle op
      cyc(0, 1, 3, 1, 0); lit("ovl_T0", 6'b001111, 0, 0, 0, 0);
      cyc(0, 1, 3, 1, 0); lit("ovl_T1", 6'b001111, 0, 1, 2, 0);
      cyc(0, 1, 3, 1, 0); lit("ovl_T2", 6'b000111, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);

      // flush in the middle of a 10-cycle op
      for (int i = 0; i < 4; i++) cyc(0, 1, 10, 0, 0);
      cyc(0, 1, 10, 0, 1); lit("flush_T4", 6'b000000, 0, 1, 6, 1);
      cyc(0, 0, 0, 0, 0);  lit("flush_T5", 6'b000000, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);

      // flush on the acceptance cycle drops the request
      cyc(0, 1, 5, 0, 1); lit("flush_acc", 6'b000000, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0); lit("flush_acc_next", 6'b000000, 0, 0, 0, 0);

      // back-to-back 2 then 3
      cyc(0, 1, 2, 0, 0); lit("b2b_T0", 6'b001111, 0, 0, 0, 0);
      cyc(0, 1, 2, 0, 0); lit("b2b_T1", 6'b000000, 1, 1, 1, 0);
      cyc(0, 1, 3, 0, 0); lit("b2b_T2", 6'b001111, 0, 0, 0, 0);
      cyc(0, 1, 3, 0, 0); lit("b2b_T3", 6'b001111, 0, 1, 2, 0);
      cyc(0, 1, 3, 0, 0); lit("b2b_T4", 6'b000000, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0); lit("b2b_T5", 6'b000000, 0, 0, 0, 0);

      // reset mid-sequence
      cyc(0, 1, 5, 0, 0);
      cyc(0, 1, 5, 0, 0);
      cyc(1, 1, 5, 1, 0); lit("rst_mid", 6'b000000, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0); lit("rst_mid_after", 6'b000000, 0, 0, 0, 0);

      // longest sequence
      cyc(0, 1, 63, 0, 0); lit("max_T0", 6'b001111, 0, 0, 0, 0);
      cyc(0, 1, 63, 0, 0); lit("max_T1", 6'b001111, 0, 1, 62, 0);
      for (int i = 2; i < 62; i++) cyc(0, 1, 63, 0, 0);
      cyc(0, 1, 63, 0, 0); lit("max_T62", 6'b000000, 1, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);  lit("max_T63", 6'b000000, 0, 0, 0, 0);

      cyc(0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
